// File: rtl/threshold_detector.sv
// threshold_detector
// Hysteresis detector on a signed sample stream. An event is declared after
// ON_COUNT consecutive valid samples above thresh_high and released after
// OFF_COUNT consecutive valid samples below thresh_low. Each finished event
// reports its peak sample and bumps a saturating event counter.
module threshold_detector #(
  parameter int DIN_WIDTH = 32,
  parameter int DIN_POINT = 31,  // informational; thresholds share the format
  parameter int ON_COUNT  = 4,
  parameter int OFF_COUNT = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,          // asynchronous, active-low
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic [DIN_WIDTH-1:0] thresh_high,
  input  logic [DIN_WIDTH-1:0] thresh_low,
  output logic                 detect,
  output logic                 detect_start,
  output logic                 detect_end,
  output logic [DIN_WIDTH-1:0] peak_value,
  output logic                 peak_valid,
  output logic [CNT_WIDTH-1:0] event_count
);

  localparam int MAX_RUN = (ON_COUNT > OFF_COUNT) ? ON_COUNT : OFF_COUNT;
  localparam int RUN_W   = $clog2(MAX_RUN) + 1;
  localparam logic [RUN_W-1:0] ON_LIM  = RUN_W'(ON_COUNT);
  localparam logic [RUN_W-1:0] OFF_LIM = RUN_W'(OFF_COUNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    ACTIVE    = 2'd2,
    RELEASING = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [RUN_W-1:0]     run_reg, run_next;
  logic [DIN_WIDTH-1:0] peak_reg, peak_next;
  logic [DIN_WIDTH-1:0] peak_value_reg, peak_value_next;
  logic [CNT_WIDTH-1:0] event_count_reg, event_count_next;
  logic                 detect_reg, detect_next;
  logic                 start_reg, start_next;
  logic                 end_reg, end_next;

  logic                 above;
  logic                 below;
  logic [DIN_WIDTH-1:0] peak_max;
  logic [RUN_W-1:0]     run_inc;

  // Signed sample classification and running-maximum candidate
  always_comb begin
    above    = $signed(din) > $signed(thresh_high);
    below    = $signed(din) < $signed(thresh_low);
    peak_max = ($signed(din) > $signed(peak_reg)) ? din : peak_reg;
    run_inc  = run_reg + RUN_W'(1);
  end

  // Next-state, run counter, peak tracking and output decisions
  always_comb begin
    state_next       = state_reg;
    run_next         = run_reg;
    peak_next        = peak_reg;
    peak_value_next  = peak_value_reg;
    event_count_next = event_count_reg;
    start_next       = 1'b0;
    end_next         = 1'b0;

    if (din_valid) begin
      case (state_reg)
        IDLE: begin
          if (above) begin
            peak_next = din;
            if (ON_COUNT == 1) begin
              state_next = ACTIVE;
              run_next   = '0;
              start_next = 1'b1;
            end else begin
              state_next = ARMING;
              run_next   = RUN_W'(1);
            end
          end
        end
        ARMING: begin
          if (above) begin
            peak_next = peak_max;
            if (run_inc == ON_LIM) begin
              state_next = ACTIVE;
              run_next   = '0;
              start_next = 1'b1;
            end else begin
              run_next = run_inc;
            end
          end else begin
            state_next = IDLE;
            run_next   = '0;
          end
        end
        ACTIVE: begin
          peak_next = peak_max;
          if (below) begin
            if (OFF_COUNT == 1) begin
              state_next       = IDLE;
              run_next         = '0;
              end_next         = 1'b1;
              peak_value_next  = peak_max;
              event_count_next = (&event_count_reg) ? event_count_reg
                                                    : event_count_reg + CNT_WIDTH'(1);
            end else begin
              state_next = RELEASING;
              run_next   = RUN_W'(1);
            end
          end
        end
        RELEASING: begin
          peak_next = peak_max;
          if (below) begin
            if (run_inc == OFF_LIM) begin
              state_next       = IDLE;
              run_next         = '0;
              end_next         = 1'b1;
              peak_value_next  = peak_max;
              event_count_next = (&event_count_reg) ? event_count_reg
                                                    : event_count_reg + CNT_WIDTH'(1);
            end else begin
              run_next = run_inc;
            end
          end else begin
            // samples between the thresholds keep the event alive
            state_next = ACTIVE;
            run_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          run_next   = '0;
        end
      endcase
    end

    detect_next = (state_next == ACTIVE) || (state_next == RELEASING);
  end

  // State and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      run_reg         <= '0;
      peak_reg        <= '0;
      peak_value_reg  <= '0;
      event_count_reg <= '0;
      detect_reg      <= 1'b0;
      start_reg       <= 1'b0;
      end_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      run_reg         <= run_next;
      peak_reg        <= peak_next;
      peak_value_reg  <= peak_value_next;
      event_count_reg <= event_count_next;
      detect_reg      <= detect_next;
      start_reg       <= start_next;
      end_reg         <= end_next;
    end
  end

  assign detect       = detect_reg;
  assign detect_start = start_reg;
  assign detect_end   = end_reg;
  assign peak_valid   = end_reg;
  assign peak_value   = peak_value_reg;
  assign event_count  = event_count_reg;

endmodule

// File: tb/tb_threshold_detector.sv
// Directed bench for threshold_detector with default parameters, Q1.31 data.
module tb_threshold_detector;

  localparam logic [31:0] V06 = 32'h4CCC_CCCD;  // 0.6
  localparam logic [31:0] V07 = 32'h5999_999A;  // 0.7
  localparam logic [31:0] V03 = 32'h2666_6666;  // 0.3
  localparam logic [31:0] V01 = 32'h0CCC_CCCD;  // 0.1
  localparam logic [31:0] VMX = 32'h7FFF_FFFF;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic [31:0] thresh_high;
  logic [31:0] thresh_low;
  logic        detect;
  logic        detect_start;
  logic        detect_end;
  logic [31:0] peak_value;
  logic        peak_valid;
  logic [15:0] event_count;

  int n_tests;
  int n_fail;

  threshold_detector dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .thresh_high  (thresh_high),
    .thresh_low   (thresh_low),
    .detect       (detect),
    .detect_start (detect_start),
    .detect_end   (detect_end),
    .peak_value   (peak_value),
    .peak_valid   (peak_valid),
    .event_count  (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
  endtask

  // Compare the single-bit outputs and the event counter in one call
  task automatic outs(input string tag, input logic d, input logic s, input logic e,
                      input logic [15:0] cnt);
    chk({tag, ".detect"},       32'(detect),       32'(d));
    chk({tag, ".detect_start"}, 32'(detect_start), 32'(s));
    chk({tag, ".detect_end"},   32'(detect_end),   32'(e));
    chk({tag, ".peak_valid"},   32'(peak_valid),   32'(e));
    chk({tag, ".event_count"},  32'(event_count),  32'(cnt));
  endtask

  // Present one sample for one clock, then settle just after the edge
  task automatic smp(input logic [31:0] d, input logic v);
    @(negedge clk);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b0;
    din         = '0;
    din_valid   = 1'b0;
    thresh_high = 32'h4000_0000;
    thresh_low  = 32'h2000_0000;

    // Reset held with random stimulus
    for (int i = 0; i < 5; i++) begin
      smp($urandom, 1'($urandom_range(0, 1)));
      outs("reset", 1'b0, 1'b0, 1'b0, 16'd0);
      chk("reset.peak_value", peak_value, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(32'd0, 1'b1);
      outs("post_reset", 1'b0, 1'b0, 1'b0, 16'd0);
    end
    $display("[TB] reset checks done");

    // Short burst never arms fully
    for (int i = 0; i < 3; i++) begin
      smp(V06, 1'b1);
      outs("burst", 1'b0, 1'b0, 1'b0, 16'd0);
    end
    smp(V01, 1'b1);
    outs("burst_end", 1'b0, 1'b0, 1'b0, 16'd0);
    $display("[TB] short burst done");

    // Full event, peak 0.7
    smp(V06, 1'b1); outs("full_a1", 1'b0, 1'b0, 1'b0, 16'd0);
    smp(V07, 1'b1); outs("full_a2", 1'b0, 1'b0, 1'b0, 16'd0);
    smp(V06, 1'b1); outs("full_a3", 1'b0, 1'b0, 1'b0, 16'd0);
    smp(V06, 1'b1); outs("full_a4", 1'b1, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 7; i++) begin
      smp(V01, 1'b1);
      outs("full_low", 1'b1, 1'b0, 1'b0, 16'd0);
    end
    smp(V01, 1'b1);
    outs("full_rel", 1'b0, 1'b0, 1'b1, 16'd1);
    chk("full.peak_value", peak_value, V07);
    smp(V01, 1'b1);
    outs("full_after", 1'b0, 1'b0, 1'b0, 16'd1);
    $display("[TB] full event done: peak=%h count=%0d", peak_value, event_count);

    // Hysteresis: in-between samples keep the event alive
    for (int i = 0; i < 3; i++) begin
      smp(V06, 1'b1);
      outs("hyst_arm", 1'b0, 1'b0, 1'b0, 16'd1);
    end
    smp(V06, 1'b1);
    outs("hyst_on", 1'b1, 1'b1, 1'b0, 16'd1);
    for (int i = 0; i < 20; i++) begin
      smp(V03, 1'b1);
      outs("hyst_mid", 1'b1, 1'b0, 1'b0, 16'd1);
    end
    for (int i = 0; i < 7; i++) begin
      smp(V01, 1'b1);
      outs("hyst_low7", 1'b1, 1'b0, 1'b0, 16'd1);
    end
    smp(V03, 1'b1);
    outs("hyst_break", 1'b1, 1'b0, 1'b0, 16'd1);
    for (int i = 0; i < 7; i++) begin
      smp(V01, 1'b1);
      outs("hyst_low", 1'b1, 1'b0, 1'b0, 16'd1);
    end
    smp(V01, 1'b1);
    outs("hyst_rel", 1'b0, 1'b0, 1'b1, 16'd2);
    chk("hyst.peak_value", peak_value, V06);
    $display("[TB] hysteresis done: peak=%h count=%0d", peak_value, event_count);

    // Full event with invalid cycles carrying a large value in between
    smp(V06, 1'b1); outs("gap_a1", 1'b0, 1'b0, 1'b0, 16'd2);
    smp(VMX, 1'b0); outs("gap_i1", 1'b0, 1'b0, 1'b0, 16'd2);
    smp(V07, 1'b1); outs("gap_a2", 1'b0, 1'b0, 1'b0, 16'd2);
    smp(VMX, 1'b0); outs("gap_i2", 1'b0, 1'b0, 1'b0, 16'd2);
    smp(V06, 1'b1); outs("gap_a3", 1'b0, 1'b0, 1'b0, 16'd2);
    smp(VMX, 1'b0); outs("gap_i3", 1'b0, 1'b0, 1'b0, 16'd2);
    smp(V06, 1'b1); outs("gap_a4", 1'b1, 1'b1, 1'b0, 16'd2);
    smp(VMX, 1'b0); outs("gap_i4", 1'b1, 1'b0, 1'b0, 16'd2);
    for (int i = 0; i < 7; i++) begin
      smp(V01, 1'b1);
      outs("gap_low", 1'b1, 1'b0, 1'b0, 16'd2);
      smp(VMX, 1'b0);
      outs("gap_lowi", 1'b1, 1'b0, 1'b0, 16'd2);
    end
    smp(V01, 1'b1);
    outs("gap_rel", 1'b0, 1'b0, 1'b1, 16'd3);
    chk("gap.peak_value", peak_value, V07);
    smp(VMX, 1'b0);
    outs("gap_after", 1'b0, 1'b0, 1'b0, 16'd3);
    $display("[TB] valid gaps done: peak=%h count=%0d", peak_value, event_count);

    // Reset in the middle of an active event
    for (int i = 0; i < 4; i++) smp(V06, 1'b1);
    smp(V01, 1'b1);
    outs("mid_active", 1'b1, 1'b0, 1'b0, 16'd3);
    #2;
    rst = 1'b0;
    #1;
    outs("mid_rst_async", 1'b0, 1'b0, 1'b0, 16'd0);
    chk("mid_rst.peak_value", peak_value, 32'd0);
    smp(V01, 1'b1);
    outs("mid_rst_hold", 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    smp(V06, 1'b1); outs("re_a1", 1'b0, 1'b0, 1'b0, 16'd0);
    smp(V07, 1'b1); outs("re_a2", 1'b0, 1'b0, 1'b0, 16'd0);
    smp(V06, 1'b1); outs("re_a3", 1'b0, 1'b0, 1'b0, 16'd0);
    smp(V06, 1'b1); outs("re_a4", 1'b1, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 7; i++) begin
      smp(V01, 1'b1);
      outs("re_low", 1'b1, 1'b0, 1'b0, 16'd0);
    end
    smp(V01, 1'b1);
    outs("re_rel", 1'b0, 1'b0, 1'b1, 16'd1);
    chk("re.peak_value", peak_value, V07);
    $display("[TB] reset mid-event done: count=%0d", event_count);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
